// File: rtl/exe_pkg.sv
// Shared opcode, operand-select and FSM encodings for execute_pipe.
// Operand selects are decoded from the 5-bit opcode by the helper functions below.
package exe_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000,
        OP_ADDI = 5'b00001,
        OP_SUBI = 5'b00010,
        OP_SUB  = 5'b00011,
        OP_AND  = 5'b01000,
        OP_OR   = 5'b01001,
        OP_XOR  = 5'b01010,
        OP_PUSH = 5'b01111,
        OP_POP  = 5'b10000,
        OP_FUN  = 5'b10100,
        OP_MUL  = 5'b10110
    } opcode_e;

    typedef enum logic [1:0] {
        A_REG = 2'd0,
        A_SP  = 2'd1,
        A_PC  = 2'd2
    } a_sel_e;

    typedef enum logic [1:0] {
        B_REG  = 2'd0,
        B_IMM  = 2'd1,
        B_STEP = 2'd2
    } b_sel_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_e;

    function automatic a_sel_e decode_a_sel(input logic [4:0] op);
        a_sel_e sel;
        case (op)
            OP_PUSH, OP_POP: sel = A_SP;
            OP_FUN:          sel = A_PC;
            default:         sel = A_REG;
        endcase
        return sel;
    endfunction

    function automatic b_sel_e decode_b_sel(input logic [4:0] op);
        b_sel_e sel;
        case (op)
            OP_ADDI, OP_SUBI: sel = B_IMM;
            OP_PUSH, OP_POP:  sel = B_STEP;
            default:          sel = B_REG;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/execute_pipe_if.sv
// Instruction-in / result-out handshake bundle for execute_pipe.
// The slave modport is the execute stage's view; master is the surrounding pipeline.
interface execute_pipe_if #(parameter int DATA_W = 32) ();
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        opcode;
    logic [DATA_W-1:0] reg_data0;
    logic [DATA_W-1:0] reg_data1;
    logic [DATA_W-1:0] sp_out;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] exe_out;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] reg_data1_o;
    logic              illegal;
    logic              busy;

    modport master (
        output in_valid, opcode, reg_data0, reg_data1, sp_out, pc, imm, out_ready,
        input  in_ready, out_valid, exe_out, mem_addr, reg_data1_o, illegal, busy
    );

    modport slave (
        input  in_valid, opcode, reg_data0, reg_data1, sp_out, pc, imm, out_ready,
        output in_ready, out_valid, exe_out, mem_addr, reg_data1_o, illegal, busy
    );
endinterface

// File: rtl/exe_mul_iter.sv
// Shift-add multiplier retiring one multiplier bit per cycle; done marks the final
// iteration and product then carries the completed low DATA_W bits.
module exe_mul_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic              active_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] mcand_r;
    logic [DATA_W-1:0] mplier_r;
    logic [DATA_W-1:0] partial_s;

    // Accumulate the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        if (mplier_r[0]) begin
            partial_s = acc_r + mcand_r;
        end else begin
            partial_s = acc_r;
        end
    end

    assign done    = active_r && (cnt_r == LAST_CNT);
    assign product = partial_s;

    // Iteration state; reset discards any partial product
    always_ff @(posedge clk) begin
        if (rst) begin
            active_r <= 1'b0;
            cnt_r    <= '0;
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
        end else if (start) begin
            active_r <= 1'b1;
            cnt_r    <= '0;
            acc_r    <= '0;
            mcand_r  <= a;
            mplier_r <= b;
        end else if (active_r) begin
            active_r <= !done;
            cnt_r    <= cnt_r + CNT_W'(1);
            acc_r    <= partial_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
        end else begin
            active_r <= active_r;
            cnt_r    <= cnt_r;
            acc_r    <= acc_r;
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
        end
    end
endmodule

// File: rtl/execute_pipe.sv
// Registered execute stage with a one-entry result register and valid/ready backpressure.
// Define EXE_MUL_EN to build in the iterative multiplier (multi-cycle MUL, MUL_RUN state).
module execute_pipe
    import exe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int WORD_BYTES = 4
) (
    input  logic         clk,
    input  logic         rst,
    execute_pipe_if.slave bus
);
    localparam logic [DATA_W-1:0] STEP = DATA_W'(WORD_BYTES);

    logic [DATA_W-1:0] a_s, b_s, res_s, addr_s, ld_exe_s, ld_addr_s;
    logic              ill_s, ld_ill_s, in_ready_s, accept_s, load_s, busy_s;
    logic              out_valid_r, illegal_r;
    logic [DATA_W-1:0] exe_out_r, mem_addr_r, rd1_r;

    // Operand selection and single-cycle ALU
    always_comb begin
        case (decode_a_sel(bus.opcode))
            A_SP:    a_s = bus.sp_out;
            A_PC:    a_s = bus.pc;
            default: a_s = bus.reg_data0;
        endcase
        case (decode_b_sel(bus.opcode))
            B_IMM:   b_s = bus.imm;
            B_STEP:  b_s = STEP;
            default: b_s = bus.reg_data1;
        endcase
        ill_s = 1'b0;
        case (bus.opcode)
            OP_ADD, OP_ADDI, OP_PUSH: res_s = a_s + b_s;
            OP_SUB, OP_SUBI, OP_POP:  res_s = a_s - b_s;
            OP_AND:                   res_s = a_s & b_s;
            OP_OR:                    res_s = a_s | b_s;
            OP_XOR:                   res_s = a_s ^ b_s;
            OP_FUN:                   res_s = a_s + STEP;
            OP_MUL: begin
                res_s = '0;
`ifdef EXE_MUL_EN
                ill_s = 1'b0;
`else
                ill_s = 1'b1;
`endif
            end
            default: begin
                res_s = a_s + b_s;
                ill_s = 1'b1;
            end
        endcase
        if (bus.opcode == OP_PUSH) begin
            addr_s = a_s;
        end else begin
            addr_s = res_s;
        end
    end

    assign in_ready_s = !rst && !busy_s && (!out_valid_r || bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;

`ifdef EXE_MUL_EN
    state_e            state_r, state_nxt_s;
    logic              mul_start_s, mul_done_s;
    logic [DATA_W-1:0] mul_product_s;

    assign mul_start_s = accept_s && (bus.opcode == OP_MUL);
    assign load_s      = (accept_s && !mul_start_s) || mul_done_s;

    exe_mul_iter #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_s),
        .a       (bus.reg_data0),
        .b       (bus.reg_data1),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:    state_nxt_s = mul_start_s ? ST_MUL_RUN : ST_IDLE;
            ST_MUL_RUN: state_nxt_s = mul_done_s ? ST_IDLE : ST_MUL_RUN;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_s = 1'b0;
        case (state_r)
            ST_MUL_RUN: busy_s = 1'b1;
            default:    busy_s = 1'b0;
        endcase
    end

    // Result source: multiplier completion or the single-cycle ALU
    always_comb begin
        if (mul_done_s) begin
            ld_exe_s  = mul_product_s;
            ld_addr_s = mul_product_s;
            ld_ill_s  = 1'b0;
        end else begin
            ld_exe_s  = res_s;
            ld_addr_s = addr_s;
            ld_ill_s  = ill_s;
        end
    end
`else
    assign busy_s    = 1'b0;
    assign load_s    = accept_s;
    assign ld_exe_s  = res_s;
    assign ld_addr_s = addr_s;
    assign ld_ill_s  = ill_s;
`endif

    // One-entry result register; a load in a draining cycle replaces the old result
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            exe_out_r   <= '0;
            mem_addr_r  <= '0;
            illegal_r   <= 1'b0;
            rd1_r       <= '0;
        end else begin
            if (load_s) begin
                out_valid_r <= 1'b1;
                exe_out_r   <= ld_exe_s;
                mem_addr_r  <= ld_addr_s;
                illegal_r   <= ld_ill_s;
            end else begin
                out_valid_r <= out_valid_r && !bus.out_ready;
                exe_out_r   <= exe_out_r;
                mem_addr_r  <= mem_addr_r;
                illegal_r   <= illegal_r;
            end
            // Store data is captured at accept so a MUL carries it to completion
            if (accept_s) begin
                rd1_r <= bus.reg_data1;
            end else begin
                rd1_r <= rd1_r;
            end
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.exe_out     = exe_out_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.reg_data1_o = rd1_r;
    assign bus.illegal     = illegal_r;
    assign bus.busy        = busy_s;
endmodule

// File: tb/tb_execute_pipe.sv
// Self-checking bench for execute_pipe: directed scenarios plus random instructions
// compared against an arithmetic reference model; honours EXE_MUL_EN.
module tb_execute_pipe;
    localparam int DATA_W     = 32;
    localparam int WORD_BYTES = 4;

    localparam logic [4:0] ADD  = 5'b00000, ADDI = 5'b00001, SUBI = 5'b00010, SUB = 5'b00011;
    localparam logic [4:0] AND_ = 5'b01000, OR_  = 5'b01001, XOR_ = 5'b01010, PUSH = 5'b01111;
    localparam logic [4:0] POP  = 5'b10000, FUN  = 5'b10100, MUL  = 5'b10110;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    execute_pipe_if #(.DATA_W(DATA_W)) bus ();

    execute_pipe #(.DATA_W(DATA_W), .WORD_BYTES(WORD_BYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour straight from the opcode table
    function automatic void model(input logic [4:0] op,
                                  input logic [DATA_W-1:0] r0, r1, sp, pc, imm,
                                  output logic [DATA_W-1:0] e, output logic [DATA_W-1:0] m,
                                  output logic il);
        logic [DATA_W-1:0] step;
        step = WORD_BYTES;
        il   = 1'b0;
        case (op)
            ADD:  e = r0 + r1;
            ADDI: e = r0 + imm;
            SUBI: e = r0 - imm;
            SUB:  e = r0 - r1;
            AND_: e = r0 & r1;
            OR_:  e = r0 | r1;
            XOR_: e = r0 ^ r1;
            PUSH: e = sp + step;
            POP:  e = sp - step;
            FUN:  e = pc + step;
`ifdef EXE_MUL_EN
            MUL:  e = r0 * r1;
`else
            MUL:  begin e = '0; il = 1'b1; end
`endif
            default: begin e = r0 + r1; il = 1'b1; end
        endcase
        m = (op == PUSH) ? sp : e;
    endfunction

    task automatic send(input string tag, input logic [4:0] op,
                        input logic [DATA_W-1:0] r0, r1, sp, pc, imm);
        logic [DATA_W-1:0] e, m;
        logic il;
        model(op, r0, r1, sp, pc, imm, e, m, il);
        bus.opcode = op; bus.reg_data0 = r0; bus.reg_data1 = r1;
        bus.sp_out = sp; bus.pc = pc; bus.imm = imm;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        chk({tag, "/in_ready"}, bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
`ifdef EXE_MUL_EN
        if (op == MUL) begin
            int lat = 1;
            int bc  = 0;
            chk({tag, "/in_ready_busy"}, bus.in_ready, 0);
            while (bus.out_valid !== 1'b1 && lat < DATA_W + 10) begin
                if (bus.busy === 1'b1) bc++;
                tick();
                lat++;
            end
            chk({tag, "/mul_latency"}, lat, DATA_W + 1);
            chk({tag, "/busy_cycles"}, bc, DATA_W);
        end
`endif
        chk({tag, "/out_valid"}, bus.out_valid, 1);
        chk({tag, "/exe_out"}, bus.exe_out, e);
        chk({tag, "/mem_addr"}, bus.mem_addr, m);
        chk({tag, "/reg_data1_o"}, bus.reg_data1_o, r1);
        chk({tag, "/illegal"}, bus.illegal, il);
    endtask

    initial begin
        logic [4:0] ops [12] = '{ADD, ADDI, SUBI, SUB, AND_, OR_, XOR_, PUSH, POP, FUN, MUL, 5'b11111};
        logic [4:0] op;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.opcode = 5'd0;
        bus.reg_data0 = '0; bus.reg_data1 = '0; bus.sp_out = '0; bus.pc = '0; bus.imm = '0;
        repeat (3) tick();
        chk("rst/out_valid", bus.out_valid, 0);
        chk("rst/exe_out", bus.exe_out, 0);
        chk("rst/mem_addr", bus.mem_addr, 0);
        chk("rst/reg_data1_o", bus.reg_data1_o, 0);
        chk("rst/illegal", bus.illegal, 0);
        chk("rst/busy", bus.busy, 0);
        chk("rst/in_ready", bus.in_ready, 0);
        rst = 1'b0;

        send("add", ADD, 32'd1, 32'd2, 32'd0, 32'd0, 32'd0);
        chk("add/const", bus.exe_out, 32'd3);

        send("addi", ADDI, 32'd1, 32'd0, 32'd0, 32'd0, 32'd3);
        chk("addi/const", bus.exe_out, 32'd4);
        send("pop", POP, 32'd0, 32'd0, 32'd4, 32'd0, 32'd0);
        chk("pop/const", bus.exe_out, 32'd0);

        send("push", PUSH, 32'd0, 32'hAA, 32'd4, 32'd0, 32'd0);
        chk("push/exe_const", bus.exe_out, 32'd8);
        chk("push/addr_const", bus.mem_addr, 32'd4);

        // Drain, then hold ADD 5+6 under backpressure for three cycles
        tick();
        chk("drain/out_valid", bus.out_valid, 0);
        bus.opcode = ADD; bus.reg_data0 = 32'd5; bus.reg_data1 = 32'd6;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        tick();
        bus.opcode = SUB; bus.reg_data0 = 32'd9; bus.reg_data1 = 32'd4;
        for (int i = 0; i < 3; i++) begin
            chk("bp/in_ready", bus.in_ready, 0);
            chk("bp/out_valid", bus.out_valid, 1);
            chk("bp/exe_out_hold", bus.exe_out, 32'd11);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp/in_ready_release", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp/second_exe", bus.exe_out, 32'd5);
        chk("bp/second_valid", bus.out_valid, 1);

        send("mul7x6", MUL, 32'd7, 32'd6, 32'd0, 32'd0, 32'd0);

        // Reset in the middle of a multiply
        bus.opcode = MUL; bus.reg_data0 = 32'd7; bus.reg_data1 = 32'd6;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        chk("midrst/busy", bus.busy, 0);
        chk("midrst/out_valid", bus.out_valid, 0);
        rst = 1'b0;
        send("post_rst_add", ADD, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0);
        chk("post_rst_add/const", bus.exe_out, 32'd2);

        // Random back-to-back instruction stream
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 5) == 0) op = 5'($urandom);
            else op = ops[$urandom_range(0, 11)];
            send("rand", op, $urandom, $urandom, $urandom, $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/execute_pipe.md
# execute_pipe

Parametrised, registered successor to the single-cycle execute stage. It accepts one decoded instruction per cycle over a valid/ready handshake and decodes the ALU A/B operand selects and the memory-address select internally from the 5-bit opcode. Results are held in a one-entry output register with backpressure. An optional iterative multiplier adds a multi-cycle MUL. The block sits between decode/register-read and memory access.

## Interface
- DATA_W, 32, datapath width in bits (≥8)
- WORD_BYTES, 4, stack/PC step constant
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  block can accept this cycle
- opcode  in  5  instruction opcode
- reg_data0, reg_data1, sp_out, pc, imm  in  DATA_W  operands
- out_valid  out  1  result register valid
- out_ready  in  1  downstream consumes result
- exe_out  out  DATA_W  ALU result
- mem_addr  out  DATA_W  memory address for stage 4
- reg_data1_o  out  DATA_W  registered reg_data1 (store data)
- illegal  out  1  registered: opcode not implemented
- busy  out  1  multi-cycle operation in progress

## Operation
- Operand A select: PUSH/POP → sp_out; FUN → pc; otherwise reg_data0.
- Operand B select: immediate forms → imm; PUSH/POP → WORD_BYTES; otherwise reg_data1.
- Opcodes and results (all arithmetic modulo 2^DATA_W, carries discarded):
  - ADD 00000 A+B; ADDI 00001 A+imm; SUBI 00010 A−imm; SUB 00011 A−B
  - AND 01000, OR 01001, XOR 01010 bitwise A,B
  - PUSH 01111: exe_out = SP+WORD_BYTES, mem_addr = SP
  - POP 10000: exe_out = SP−WORD_BYTES, mem_addr = SP−WORD_BYTES
  - FUN 10100: exe_out = PC+WORD_BYTES
  - MUL 10110: low DATA_W bits of reg_data0×reg_data1
  - Any other opcode: exe_out = A+B, illegal = 1.
- mem_addr = exe_out for all non-PUSH opcodes.
- in_ready = !rst && !busy && (!out_valid || out_ready).
- An instruction is accepted when in_valid && in_ready.
- States: IDLE, MUL_RUN.
  - IDLE→MUL_RUN on MUL accept.
  - MUL_RUN→IDLE after DATA_W iterations; result loads the output register.
- Output register is a single entry. It loads on single-cycle accept or MUL completion and clears on out_valid && out_ready with no new load. Load and drain in the same cycle: the new result replaces the old one and out_valid stays 1.
- While out_valid && !out_ready, all outputs hold stable.

## Timing
- Reset values: out_valid=0, exe_out=0, mem_addr=0, reg_data1_o=0, illegal=0, busy=0, state IDLE. in_ready=0 while rst=1.
- Single-cycle ops: accept in cycle N → out_valid in N+1. Sustained throughput is 1/cycle while out_ready=1.
- MUL: accept in N → busy high for N+1..N+DATA_W → out_valid in N+DATA_W+1. in_ready=0 throughout.
- A MUL is accepted only when the output slot is empty or draining, so completion never collides with a held result.
- rst asserted mid-MUL aborts the operation; the partial product is discarded.

## Configuration
- EXE_MUL_EN defined: the iterative multiplier and the MUL_RUN state are compiled in.
- Without EXE_MUL_EN: MUL is single-cycle with exe_out=0 and illegal=1, and busy is tied to 0.

## Structure
- exe_pkg holds:
  - opcode localparams/enum
  - A/B select enums
  - state enum
- Sub-module exe_mul_iter (shift-add, one multiplier bit per cycle) has ports start, a, b, done, product.
  - Instantiated only under EXE_MUL_EN.

## Test plan
- ADD: reg_data0=1, reg_data1=2 → exe_out=3, illegal=0, one cycle after accept.
- ADDI then POP back-to-back: reg_data0=1, imm=3, then sp_out=4.
  - Consecutive results: exe_out=4; then exe_out=0, mem_addr=0.
- PUSH: sp_out=4, reg_data1=0xAA → exe_out=8, mem_addr=4, reg_data1_o=0xAA.
- Backpressure: out_ready=0 for 3 cycles after ADD 5+6 → exe_out holds 11, in_ready=0, second instruction waits; accepted in the cycle out_ready rises.
- MUL (EXE_MUL_EN, DATA_W=32): 7×6.
  - Result: exe_out=42 exactly 33 cycles after accept; busy=1 for 32 cycles.
  - Without the macro: exe_out=0, illegal=1 after 1 cycle.
- Reset mid-MUL at iteration 10:
  - Next cycle: busy=0, out_valid=0.
  - A following ADD 1+1 returns 2 normally.
